sdram_init_monitor: RTL and testbench
=====================================

// Module: sdram_init_monitor
// PURPOSE
//  Responder-side checker for the SDRAM power-up sequence. Samples the command/bank/address bus
//  driven by the init sequencer, enforces power-up wait, PRE-all, tRP, >=CNT_AR AUTO REFRESH with
//  tRFC, MRS and tMRD, decodes the programmed mode register and flags the first protocol violation.
//  Sits beside the controller in simulation and FPGA builds; it never drives the SDRAM pins.
// PARAMETERS
//  CNT_WAIT  20000  power-up cycles before first non-NOP command is legal
//  TRP       2      min cycles from PRE to next non-NOP command
//  TRFC      7      min cycles from AR to next non-NOP command
//  TMRD      2      min cycles from MRS to READY / next non-NOP command
//  CNT_AR    2      min AUTO REFRESH count before MRS
// PORTS
//  init_clk      in   1   clock
//  init_rst_n    in   1   reset, asynchronous, active-low
//  init_cmd      in   4   {CS#,RAS#,CAS#,WE#}
//  init_bank     in   2   bank address
//  init_addr     in   13  address bus (A10 = all-banks on PRE; A12..A0 = mode on MRS)
//  mon_ready     out  1   sequence completed legally
//  mon_err       out  1   sticky violation flag
//  mon_err_code  out  3   first violation code (0 = none)
//  ar_count      out  4   AUTO REFRESH commands seen, saturates at 15
//  mode_bl       out  3   decoded A2..A0; mode_cl out 3 decoded A6..A4; mode_wb out 1 decoded A9
// BEHAVIOUR
//  - Reset: all outputs 0; state PWR; cycle/gap counters 0. Reset mid-sequence restarts at PWR.
//  - NOP = 4'b0111; any cmd with CS#=1 is deselect, treated as NOP. All other codes are commands.
//  - Outputs registered: response visible 1 cycle after the offending/qualifying sample.
//  - States: PWR -> W_PRE -> T_RP -> W_AR -> T_RFC -> W_MRS -> T_MRD -> READY; ERR absorbing.
//    PWR: count to CNT_WAIT-1 (16-bit, saturating); non-NOP before that -> ERR code 1.
//    W_PRE: PRE(0010) with A10=1 -> T_RP; PRE with A10=0 -> code 2; other cmd -> code 5.
//    T_RP: gap counter from PRE cycle; non-NOP before gap>=TRP -> code 3; else -> W_AR.
//    W_AR: AR(0001) -> T_RFC, ar_count+1; other cmd -> code 5.
//    T_RFC: non-NOP before gap>=TRFC -> code 4; on expiry -> W_AR if ar_count<CNT_AR else W_MRS.
//    W_MRS: extra AR legal (-> T_RFC, count+1); MRS(0000) with bank=00 -> latch mode, T_MRD;
//           MRS with bank!=00 or other cmd -> code 5.
//    T_MRD: non-NOP before gap>=TMRD -> code 6; expiry -> READY, mon_ready=1.
//    READY: MRS re-decodes mode fields; all other commands ignored; mon_ready stays 1.
//  - Gap counter 4-bit, cleared on each command cycle, saturating; expiry at gap==N-1 with NOP.
//  - Exactly the first error is recorded; mon_err/mon_err_code hold until reset; mon_ready stays 0.
// CONFIGURATION
//  SDRAM_INIT_MON_MRS_CHECK_EN defined: MRS with CL not in {2,3}, BL not in {0,1,2,3,7}, or
//   nonzero A12..A10/A8..A7 -> ERR code 7 (mode fields still latched).
//  Undefined: MRS fields latched verbatim, code 7 never produced.
// STRUCTURE
//  sdram_pkg: CMD_NOP/PRE/AR/MRS constants, state enum, error-code localparams (1..7).
//  Sub-module sdram_gap_timer: loadable saturating counter with elapsed(N) flag; one instance.
// TESTING (bench uses CNT_WAIT=20, TRP=2, TRFC=7, TMRD=2, CNT_AR=2)
//  - Legal seq: NOP x20, PRE A10=1, NOP x2, AR, NOP x7, AR, NOP x7, MRS addr=0x037 -> mon_ready=1,
//    mode_cl=3, mode_bl=7, mode_wb=0, ar_count=2, mon_err=0.
//  - PRE at cycle 10 after reset -> mon_err=1, code 1 next cycle; later legal traffic ignored.
//  - PRE with A10=0 -> code 2; AR 1 cycle after PRE -> code 3; AR 3 cycles after AR -> code 4.
//  - MRS after single AR -> code 5; 3 ARs then MRS -> ready, ar_count=3.
//  - MRS addr=0x057 (CL=5): with MRS_CHECK_EN -> code 7; without -> ready, mode_cl=5.
//  - Assert init_rst_n low during T_RFC -> all outputs 0; full legal seq afterwards reaches ready.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared constants, state encoding and helpers for the SDRAM power-up monitor.
// Build option: SDRAM_INIT_MON_MRS_CHECK_EN enables the mode-register legality
// check (mode_bad) in sdram_init_monitor.
package sdram_pkg;

  // {CS#,RAS#,CAS#,WE#}
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_AR  = 4'b0001;
  localparam logic [3:0] CMD_MRS = 4'b0000;

  typedef enum logic [3:0] {
    ST_PWR,
    ST_W_PRE,
    ST_T_RP,
    ST_W_AR,
    ST_T_RFC,
    ST_W_MRS,
    ST_T_MRD,
    ST_READY,
    ST_ERR
  } mon_state_e;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_PWR     = 3'd1;  // command during power-up wait
  localparam logic [2:0] ERR_PRE_A10 = 3'd2;  // PRE without all-banks
  localparam logic [2:0] ERR_TRP     = 3'd3;  // tRP too short
  localparam logic [2:0] ERR_TRFC    = 3'd4;  // tRFC too short
  localparam logic [2:0] ERR_SEQ     = 3'd5;  // out-of-order command
  localparam logic [2:0] ERR_TMRD    = 3'd6;  // tMRD too short
  localparam logic [2:0] ERR_MODE    = 3'd7;  // illegal mode register value

  // Deselect (CS#=1) behaves exactly like NOP.
  function automatic logic cmd_is_nop(input logic [3:0] cmd);
    return cmd[3] || (cmd == CMD_NOP);
  endfunction

  // Gap-timer threshold for a minimum spacing of n cycles: the counter reads 0
  // on the first cycle after the command, so the spacing is met at n-1.
  // Clamped to the 4-bit counter range.
  function automatic logic [3:0] gap_lim(input int n);
    if (n <= 1)      return 4'd0;
    else if (n > 16) return 4'hF;
    else             return 4'(n - 1);
  endfunction

  // Mode values this controller family supports: CL 2/3, BL 1/2/4/8/page,
  // and reserved / test-mode bits zero.
  function automatic logic mode_bad(input logic [12:0] a);
    logic cl_ok, bl_ok;
    cl_ok = (a[6:4] == 3'd2) || (a[6:4] == 3'd3);
    bl_ok = (a[2:0] <= 3'd3) || (a[2:0] == 3'd7);
    return !cl_ok || !bl_ok || (a[12:10] != 3'd0) || (a[8:7] != 2'd0);
  endfunction

endpackage

// File: rtl/sdram_gap_timer.sv
// Saturating cycle counter measuring the gap since the last SDRAM command.
// Cleared on every command cycle; elapsed flags that the selected threshold
// has been reached.
module sdram_gap_timer #(
  parameter int W = 4
) (
  input  logic         init_clk,
  input  logic         init_rst_n,
  input  logic         clr,
  input  logic [W-1:0] lim,
  output logic         elapsed
);

  logic [W-1:0] cnt;

  // Restart on each command, otherwise count up and stick at all-ones.
  always_ff @(posedge init_clk or negedge init_rst_n) begin
    if (!init_rst_n)       cnt <= '0;
    else if (clr)          cnt <= '0;
    else if (cnt != '1)    cnt <= cnt + 1'b1;
  end

  assign elapsed = (cnt >= lim);

endmodule

// File: rtl/sdram_init_monitor.sv
// Passive checker for the SDRAM power-up sequence: power-up wait, PRE-all,
// tRP, CNT_AR x (AR + tRFC), MRS, tMRD, then READY. The first violation is
// latched as an error code and the monitor parks in ERR until reset.
// Build option: SDRAM_INIT_MON_MRS_CHECK_EN rejects unsupported mode values
// on the initial MRS with error code 7.
module sdram_init_monitor
  import sdram_pkg::*;
#(
  parameter int CNT_WAIT = 20000,
  parameter int TRP      = 2,
  parameter int TRFC     = 7,
  parameter int TMRD     = 2,
  parameter int CNT_AR   = 2
) (
  input  logic        init_clk,
  input  logic        init_rst_n,
  input  logic [3:0]  init_cmd,
  input  logic [1:0]  init_bank,
  input  logic [12:0] init_addr,
  output logic        mon_ready,
  output logic        mon_err,
  output logic [2:0]  mon_err_code,
  output logic [3:0]  ar_count,
  output logic [2:0]  mode_bl,
  output logic [2:0]  mode_cl,
  output logic        mode_wb
);

  localparam int          PWR_LAST_I = (CNT_WAIT > 1) ? CNT_WAIT - 1 : 0;
  localparam logic [15:0] PWR_LAST   = (PWR_LAST_I > 65535) ? 16'hFFFF : 16'(PWR_LAST_I);
  localparam logic [3:0]  LIM_RP     = gap_lim(TRP);
  localparam logic [3:0]  LIM_RFC    = gap_lim(TRFC);
  localparam logic [3:0]  LIM_MRD    = gap_lim(TMRD);
  localparam logic [3:0]  AR_MIN     = (CNT_AR > 15) ? 4'hF : 4'(CNT_AR);

  mon_state_e  state, state_nxt;
  logic [2:0]  err_code, err_code_nxt;
  logic [15:0] pwr_cnt;
  logic        is_nop;
  logic        is_mrs0;
  logic        ar_inc;
  logic        mode_ld;
  logic        err_hit;
  logic [2:0]  err_val;
  logic [3:0]  lim;
  logic        gap_done;
  logic        unused_addr;

  assign is_nop  = cmd_is_nop(init_cmd);
  assign is_mrs0 = (init_cmd == CMD_MRS) && (init_bank == 2'b00);

  // Address bits that only matter to the optional mode check.
  assign unused_addr = ^{init_addr[12:11], init_addr[8:7], init_addr[3]};

  sdram_gap_timer #(.W(4)) u_gap (
    .init_clk   (init_clk),
    .init_rst_n (init_rst_n),
    .clr        (!is_nop),
    .lim        (lim),
    .elapsed    (gap_done)
  );

  // State register.
  always_ff @(posedge init_clk or negedge init_rst_n) begin
    if (!init_rst_n) state <= ST_PWR;
    else             state <= state_nxt;
  end

  // Sequence checking: next state, error capture and side-effect strobes.
  always_comb begin
    state_nxt    = state;
    err_code_nxt = err_code;
    ar_inc       = 1'b0;
    mode_ld      = 1'b0;
    err_hit      = 1'b0;
    err_val      = ERR_NONE;
    lim          = LIM_RP;
    case (state)
      ST_PWR: begin
        if (!is_nop)                   begin err_hit = 1'b1; err_val = ERR_PWR; end
        else if (pwr_cnt >= PWR_LAST)  state_nxt = ST_W_PRE;
      end
      ST_W_PRE: begin
        if (!is_nop) begin
          if (init_cmd == CMD_PRE && init_addr[10]) state_nxt = ST_T_RP;
          else if (init_cmd == CMD_PRE)             begin err_hit = 1'b1; err_val = ERR_PRE_A10; end
          else                                      begin err_hit = 1'b1; err_val = ERR_SEQ; end
        end
      end
      ST_T_RP: begin
        lim = LIM_RP;
        if (!is_nop)        begin err_hit = 1'b1; err_val = ERR_TRP; end
        else if (gap_done)  state_nxt = ST_W_AR;
      end
      ST_W_AR: begin
        if (!is_nop) begin
          if (init_cmd == CMD_AR) begin state_nxt = ST_T_RFC; ar_inc = 1'b1; end
          else                    begin err_hit = 1'b1; err_val = ERR_SEQ; end
        end
      end
      ST_T_RFC: begin
        lim = LIM_RFC;
        if (!is_nop)        begin err_hit = 1'b1; err_val = ERR_TRFC; end
        else if (gap_done)  state_nxt = (ar_count < AR_MIN) ? ST_W_AR : ST_W_MRS;
      end
      ST_W_MRS: begin
        if (!is_nop) begin
          if (init_cmd == CMD_AR) begin
            state_nxt = ST_T_RFC;
            ar_inc    = 1'b1;
          end else if (is_mrs0) begin
            mode_ld   = 1'b1;
            state_nxt = ST_T_MRD;
`ifdef SDRAM_INIT_MON_MRS_CHECK_EN
            if (mode_bad(init_addr)) begin err_hit = 1'b1; err_val = ERR_MODE; end
`endif
          end else begin
            err_hit = 1'b1; err_val = ERR_SEQ;
          end
        end
      end
      ST_T_MRD: begin
        lim = LIM_MRD;
        if (!is_nop)        begin err_hit = 1'b1; err_val = ERR_TMRD; end
        else if (gap_done)  state_nxt = ST_READY;
      end
      // Later mode reloads are tracked but never judged; ready stays up.
      ST_READY: begin
        if (is_mrs0) mode_ld = 1'b1;
      end
      ST_ERR:  state_nxt = ST_ERR;
      default: state_nxt = ST_ERR;
    endcase
    if (err_hit) begin
      state_nxt    = ST_ERR;
      err_code_nxt = err_val;
    end
  end

  // Power-up wait counter, running only while in PWR.
  always_ff @(posedge init_clk or negedge init_rst_n) begin
    if (!init_rst_n)                                  pwr_cnt <= '0;
    else if (state == ST_PWR && pwr_cnt != 16'hFFFF)  pwr_cnt <= pwr_cnt + 16'd1;
  end

  // Registered observables: error code, refresh count and decoded mode.
  always_ff @(posedge init_clk or negedge init_rst_n) begin
    if (!init_rst_n) begin
      err_code <= ERR_NONE;
      ar_count <= '0;
      mode_bl  <= '0;
      mode_cl  <= '0;
      mode_wb  <= 1'b0;
    end else begin
      err_code <= err_code_nxt;
      if (ar_inc && ar_count != 4'hF) ar_count <= ar_count + 4'd1;
      if (mode_ld) begin
        mode_bl <= init_addr[2:0];
        mode_cl <= init_addr[6:4];
        mode_wb <= init_addr[9];
      end
    end
  end

  assign mon_ready    = (state == ST_READY);
  assign mon_err      = (state == ST_ERR);
  assign mon_err_code = err_code;

endmodule

// File: tb/tb_sdram_init_monitor.sv
// Directed bench for sdram_init_monitor with short timing parameters.
module tb_sdram_init_monitor;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] DES = 4'b1000;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] AR  = 4'b0001;
  localparam logic [3:0] MRS = 4'b0000;
  localparam logic [12:0] A10 = 13'h400;

  logic        init_clk = 1'b0;
  logic        init_rst_n = 1'b0;
  logic [3:0]  init_cmd = NOP;
  logic [1:0]  init_bank = 2'b00;
  logic [12:0] init_addr = '0;
  logic        mon_ready, mon_err, mode_wb;
  logic [2:0]  mon_err_code, mode_bl, mode_cl;
  logic [3:0]  ar_count;

  int n_chk  = 0;
  int n_pass = 0;

  sdram_init_monitor #(
    .CNT_WAIT(20), .TRP(2), .TRFC(7), .TMRD(2), .CNT_AR(2)
  ) dut (
    .init_clk     (init_clk),
    .init_rst_n   (init_rst_n),
    .init_cmd     (init_cmd),
    .init_bank    (init_bank),
    .init_addr    (init_addr),
    .mon_ready    (mon_ready),
    .mon_err      (mon_err),
    .mon_err_code (mon_err_code),
    .ar_count     (ar_count),
    .mode_bl      (mode_bl),
    .mode_cl      (mode_cl),
    .mode_wb      (mode_wb)
  );

  always #5 init_clk = ~init_clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Drive one bus sample; returns 1 time unit after the sampling edge.
  task automatic cyc(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a);
    init_cmd = c; init_bank = b; init_addr = a;
    @(posedge init_clk); #1;
  endtask

  task automatic idle(input int n, input logic [3:0] c);
    for (int i = 0; i < n; i++) cyc(c, 2'b00, 13'h0);
  endtask

  task automatic do_reset();
    init_rst_n = 1'b0;
    init_cmd = NOP; init_bank = 2'b00; init_addr = '0;
    repeat (2) @(posedge init_clk);
    #1;
    init_rst_n = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdy"},  16'(mon_ready),    16'h0);
    chk({tag, "_err"},  16'(mon_err),      16'h0);
    chk({tag, "_code"}, 16'(mon_err_code), 16'h0);
    chk({tag, "_arc"},  16'(ar_count),     16'h0);
    chk({tag, "_mode"}, 16'({mode_wb, mode_cl, mode_bl}), 16'h0);
  endtask

  // Legal traffic up to the point where MRS is expected.
  task automatic to_w_mrs();
    idle(20, NOP);
    cyc(PRE, 2'b00, A10);
    idle(2, NOP);
    cyc(AR, 2'b00, 13'h0);
    idle(7, NOP);
    cyc(AR, 2'b00, 13'h0);
    idle(7, NOP);
  endtask

  initial begin
    // Reset values
    do_reset();
    chk_all_zero("reset");

    // Legal sequence
    to_w_mrs();
    chk("legal_arc_pre_mrs", 16'(ar_count), 16'd2);
    cyc(MRS, 2'b00, 13'h037);
    chk("legal_cl",  16'(mode_cl), 16'd3);
    chk("legal_bl",  16'(mode_bl), 16'd7);
    chk("legal_wb",  16'(mode_wb), 16'd0);
    chk("legal_rdy_in_tmrd", 16'(mon_ready), 16'd0);
    idle(2, NOP);
    chk("legal_rdy", 16'(mon_ready), 16'd1);
    chk("legal_err", 16'(mon_err),   16'd0);
    cyc(PRE, 2'b00, 13'h0);
    chk("ready_ignores_pre_rdy", 16'(mon_ready), 16'd1);
    chk("ready_ignores_pre_err", 16'(mon_err),   16'd0);

    // Early PRE during power-up wait, then sticky error
    do_reset();
    idle(10, NOP);
    cyc(PRE, 2'b00, A10);
    chk("pwr_err",  16'(mon_err),      16'd1);
    chk("pwr_code", 16'(mon_err_code), 16'd1);
    to_w_mrs();
    cyc(MRS, 2'b00, 13'h037);
    idle(2, NOP);
    chk("sticky_code", 16'(mon_err_code), 16'd1);
    chk("sticky_rdy",  16'(mon_ready),    16'd0);
    chk("sticky_arc",  16'(ar_count),     16'd0);
    chk("sticky_cl",   16'(mode_cl),      16'd0);

    // PRE one cycle short of the power-up wait
    do_reset();
    idle(19, NOP);
    cyc(PRE, 2'b00, A10);
    chk("pwr_edge_code", 16'(mon_err_code), 16'd1);

    // PRE without A10
    do_reset();
    idle(20, NOP);
    cyc(PRE, 2'b00, 13'h0);
    chk("pre_a10_code", 16'(mon_err_code), 16'd2);

    // AR one cycle after PRE
    do_reset();
    idle(20, NOP);
    cyc(PRE, 2'b00, A10);
    cyc(AR, 2'b00, 13'h0);
    chk("trp_code", 16'(mon_err_code), 16'd3);
    chk("trp_arc",  16'(ar_count),     16'd0);

    // AR three cycles after AR
    do_reset();
    idle(20, NOP);
    cyc(PRE, 2'b00, A10);
    idle(2, NOP);
    cyc(AR, 2'b00, 13'h0);
    idle(2, NOP);
    cyc(AR, 2'b00, 13'h0);
    chk("trfc_code", 16'(mon_err_code), 16'd4);
    chk("trfc_arc",  16'(ar_count),     16'd1);

    // MRS after a single AR
    do_reset();
    idle(20, NOP);
    cyc(PRE, 2'b00, A10);
    idle(2, NOP);
    cyc(AR, 2'b00, 13'h0);
    idle(7, NOP);
    cyc(MRS, 2'b00, 13'h037);
    chk("one_ar_code", 16'(mon_err_code), 16'd5);
    chk("one_ar_rdy",  16'(mon_ready),    16'd0);

    // Command inside tMRD
    do_reset();
    to_w_mrs();
    cyc(MRS, 2'b00, 13'h037);
    cyc(AR, 2'b00, 13'h0);
    chk("tmrd_code", 16'(mon_err_code), 16'd6);

    // MRS to a non-zero bank is not the mode register
    do_reset();
    to_w_mrs();
    cyc(MRS, 2'b01, 13'h037);
    chk("mrs_bank_code", 16'(mon_err_code), 16'd5);

    // Three refreshes, deselects as idle cycles
    do_reset();
    to_w_mrs();
    cyc(AR, 2'b00, 13'h0);
    chk("ar3_arc", 16'(ar_count), 16'd3);
    idle(7, DES);
    cyc(MRS, 2'b00, 13'h037);
    idle(2, DES);
    chk("ar3_rdy", 16'(mon_ready), 16'd1);
    chk("ar3_err", 16'(mon_err),   16'd0);

    // CL=5 mode value
    do_reset();
    to_w_mrs();
    cyc(MRS, 2'b00, 13'h057);
    chk("cl5_cl", 16'(mode_cl), 16'd5);
`ifdef SDRAM_INIT_MON_MRS_CHECK_EN
    chk("cl5_code", 16'(mon_err_code), 16'd7);
    chk("cl5_err",  16'(mon_err),      16'd1);
`else
    idle(2, NOP);
    chk("cl5_rdy",  16'(mon_ready),    16'd1);
    chk("cl5_code", 16'(mon_err_code), 16'd0);
`endif

    // Asynchronous reset while in T_RFC, then a full legal run
    do_reset();
    idle(20, NOP);
    cyc(PRE, 2'b00, A10);
    idle(2, NOP);
    cyc(AR, 2'b00, 13'h0);
    idle(3, NOP);
    chk("mid_arc", 16'(ar_count), 16'd1);
    init_rst_n = 1'b0;
    #2;
    chk_all_zero("mid_rst");
    @(posedge init_clk); #1;
    init_rst_n = 1'b1;
    to_w_mrs();
    cyc(MRS, 2'b00, 13'h037);
    idle(2, NOP);
    chk("post_rst_rdy", 16'(mon_ready), 16'd1);
    chk("post_rst_arc", 16'(ar_count),  16'd2);
    chk("post_rst_err", 16'(mon_err),   16'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
